unified_mem_resp: RTL and testbench
===================================

# unified_mem_resp

Single-port memory responder serving the processor's unified instruction/data memory over a valid/ready request–response handshake. The pipeline's fetch stage or MEM stage acts as the initiator. This block is the responder end: it accepts one request per cycle, performs RISC-V byte/half/word loads and stores with load sign/zero extension, and returns exactly one response per accepted request. Responses are held under backpressure, and misaligned or illegal accesses are flagged.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; memory holds 2**(ADDR_W-2) 32-bit words.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator consumes the response this cycle
- rsp_rdata  output  32  load result after extension; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal request
- stat_rd, stat_wr, stat_err  output  16 each  statistics counters (see Configuration)

Reset is asynchronous and active-low, on a single clock domain.

## Operation
- Storage is little-endian. Word index is req_addr[ADDR_W-1:2]; byte lane is req_addr[1:0]. Addresses wrap modulo 2**ADDR_W.
- The FSM has two states, IDLE and RESP.
  - IDLE: req_ready=1 and rsp_valid=0. An accepted request (req_valid & req_ready) moves the FSM to RESP.
  - RESP: rsp_valid=1 and req_ready=rsp_ready.
    - rsp_ready=1 with req_valid=1: the response retires and the new request is accepted in the same edge; state stays RESP.
    - rsp_ready=1 with req_valid=0: move to IDLE.
    - rsp_ready=0: hold. rsp_rdata and rsp_err stay stable.
- Store on acceptance:
  - Only the addressed lanes are written: SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes.
  - Data comes from req_wdata[7:0], [15:0], or [31:0] respectively.
  - The response carries rsp_rdata=0 and rsp_err=0.
- Load on acceptance:
  - The word is read at the accepting edge and the lane(s) are extracted.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Illegal funct3: loads 011/110/111, stores ≥011.
- On error: no memory write; response carries rsp_err=1 and rsp_rdata=0.
- A load accepted the cycle after a store to the same word returns the new data. Stores commit at their accepting edge.
- Memory contents are not affected by reset.

## Timing
- Latency: a request accepted at edge k produces rsp_valid=1 from edge k until its retirement edge.
- Throughput: 1 request per cycle while rsp_ready=1.
- req_ready is combinational from state and rsp_ready. There is no combinational path from req_* to rsp_*.
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, stat_*=0. With the FSM in IDLE, req_ready=1 immediately after reset deassertion.
- Reset mid-response: the pending response is dropped and its store remains committed.
- Initiator rule: req_* must stay stable while req_valid=1 and req_ready=0.

## Configuration
- MEM_RESP_STATS_EN defined:
  - stat_rd counts accepted non-error loads.
  - stat_wr counts accepted non-error stores.
  - stat_err counts accepted erroneous requests.
  - Each counter increments at the accepting edge and saturates at 16'hFFFF.
- MEM_RESP_STATS_EN undefined: the counters are not built, and stat_* are tied to 0.

## Test plan
- Reset with rst=0 -> rsp_valid=0, rsp_rdata=0, req_ready=1.
- SW 0x8badf00d @0x10, then LW @0x10 with rsp_ready=1, back-to-back -> responses on consecutive cycles. Second response: rdata=0x8badf00d, err=0.
- After the store above:
  - LB @0x13 -> 0xffffff8b.
  - LBU @0x13 -> 0x0000008b.
  - LH @0x12 -> 0xffff8bad.
  - LHU @0x10 -> 0x0000f00d.
- SB 0x5a @0x11 then LW @0x10 -> 0x8bad5a0d.
- LW @0x12, SH @0x13, and funct3=011 load -> each response has err=1 and rdata=0. A following LW @0x10 is unchanged. With MEM_RESP_STATS_EN, stat_err=3.
- Hold rsp_ready=0 for 3 cycles with a pending LW -> rsp_rdata stable and req_ready=0. Assert rst mid-hold -> rsp_valid=0 next cycle. Stored data survives.

Source files
------------

// File: rtl/unified_mem_resp_if.sv
// Request/response handshake bundle between a pipeline initiator (fetch or MEM stage)
// and the unified memory responder.
interface unified_mem_resp_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/unified_mem_resp.sv
// Unified instruction/data memory responder: RV32I byte/half/word loads and stores, one response per request.
// Optional statistics counters are built when MEM_RESP_STATS_EN is defined; otherwise stat_* read as 0.
module unified_mem_resp #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  unified_mem_resp_if.slave   bus,
  output logic [15:0]         stat_rd,
  output logic [15:0]         stat_wr,
  output logic [15:0]         stat_err
);
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << WORD_W;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem [DEPTH];
  logic              accept_c;
  logic [WORD_W-1:0] idx;
  logic [1:0]        lane;
  logic [1:0]        size;
  logic              legal, misal, err_c;
  logic [31:0]       rd_word, shifted, ext;
  logic [3:0]        be;
  logic [31:0]       wd_sh;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.req_ready = bus.rsp_ready;
        if (bus.rsp_ready && !bus.req_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept_c = bus.req_valid & bus.req_ready;

  // Request decode, load extraction and store lane steering
  always_comb begin
    idx   = bus.req_addr[ADDR_W-1:2];
    lane  = bus.req_addr[1:0];
    size  = bus.req_funct3[1:0];
    if (bus.req_we) legal = !bus.req_funct3[2] && (size != 2'b11);
    else            legal = (size != 2'b11) && !(bus.req_funct3[2] && size == 2'b10);
    misal = (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
    err_c = !legal || misal;

    rd_word = mem[idx];
    shifted = rd_word >> {lane, 3'b000};
    case (size)
      2'b00:   ext = bus.req_funct3[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   ext = bus.req_funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase

    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    wd_sh = bus.req_wdata << {lane, 3'b000};
  end

  // Storage has no reset; stores commit at their accepting edge
  always_ff @(posedge clk) begin
    if (accept_c && bus.req_we && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
      end
    end
  end

  // State and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        err_q   <= err_c;
        rdata_q <= (err_c || bus.req_we) ? 32'd0 : ext;
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  // Saturating per-class counters, bumped at the accepting edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (accept_c) begin
      if (err_c) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (bus.req_we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign stat_rd  = rd_cnt_q;
  assign stat_wr  = wr_cnt_q;
  assign stat_err = err_cnt_q;
`else
  assign stat_rd  = '0;
  assign stat_wr  = '0;
  assign stat_err = '0;
`endif
endmodule

// File: tb/tb_unified_mem_resp.sv
// Bench for unified_mem_resp: directed vector table, randomized traffic against a byte-array
// reference model, and hold/reset corner sequences.
module tb_unified_mem_resp;
  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] stat_rd, stat_wr, stat_err;

  always #5 clk = ~clk;

  unified_mem_resp_if #(.ADDR_W(ADDR_W)) bus ();

  unified_mem_resp #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .stat_rd  (stat_rd),
    .stat_wr  (stat_wr),
    .stat_err (stat_err)
  );

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus outcome counters
  logic [7:0] mb [256];
  int m_rd, m_wr, m_err;

  function automatic void model(input bit we, input logic [2:0] f3, input logic [7:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int sz;
    bit legal;
    logic [31:0] v;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    sz = 1 << f3[1:0];
    e  = !legal || ((int'(a) % sz) != 0);
    rd = '0;
    if (e) begin
      m_err++;
      return;
    end
    if (we) begin
      for (int i = 0; i < sz; i++) mb[(int'(a) + i) % 256] = wd[8*i +: 8];
      m_wr++;
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[(int'(a) + i) % 256]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (~32'd0 << (8*sz));
      rd = v;
      m_rd++;
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          tbl;
    logic [31:0] t_rdata;
    logic        t_err;
  } exp_t;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[20];
  bit          accepted;
  bit          rand_rdy;
  bit          cur_tbl;
  logic [31:0] cur_t_rdata;
  logic        cur_t_err;

  // One clock: check at the falling edge, then step past the rising edge
  task automatic cycle();
    exp_t e;
    logic [31:0] r;
    logic er;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
    check("req_ready", 32'(bus.req_ready), 32'((exp_q.size() == 0) || bus.rsp_ready));
    if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rsp_rdata", bus.rsp_rdata, e.rdata);
      check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      if (e.tbl) begin
        check("vec_rdata", bus.rsp_rdata, e.t_rdata);
        check("vec_err", 32'(bus.rsp_err), 32'(e.t_err));
      end
    end
    accepted = 1'b0;
    if (bus.req_valid && bus.req_ready) begin
      model(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata, r, er);
      e.rdata   = r;
      e.err     = er;
      e.tbl     = cur_tbl;
      e.t_rdata = cur_t_rdata;
      e.t_err   = cur_t_err;
      exp_q.push_back(e);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: request at addr 0x%02h never accepted", a);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy      = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [15:0] sat(input int c);
`ifdef MEM_RESP_STATS_EN
    return (c > 65535) ? 16'hFFFF : 16'(c);
`else
    return (c < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic check_stats();
    check("stat_rd", 32'(stat_rd), 32'(sat(m_rd)));
    check("stat_wr", 32'(stat_wr), 32'(sat(m_wr)));
    check("stat_err", 32'(stat_err), 32'(sat(m_err)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd, held;
    bit          we;
    logic [2:0]  f3;
    logic [7:0]  a;
    int          sz;

    tbl[0]  = '{1'b1, 3'd2, 8'h10, 32'h8badf00d, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 3'd2, 8'h10, 32'h0,        32'h8badf00d, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 8'h13, 32'h0,        32'hffffff8b, 1'b0};
    tbl[3]  = '{1'b0, 3'd4, 8'h13, 32'h0,        32'h0000008b, 1'b0};
    tbl[4]  = '{1'b0, 3'd1, 8'h12, 32'h0,        32'hffff8bad, 1'b0};
    tbl[5]  = '{1'b0, 3'd5, 8'h10, 32'h0,        32'h0000f00d, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, 8'h11, 32'ha5a5a55a, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 3'd2, 8'h10, 32'h0,        32'h8bad5a0d, 1'b0};
    tbl[8]  = '{1'b0, 3'd2, 8'h12, 32'h0,        32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 8'h13, 32'hffffffff, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 3'd3, 8'h10, 32'h0,        32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 3'd2, 8'h10, 32'h0,        32'h8bad5a0d, 1'b0};
    tbl[12] = '{1'b1, 3'd2, 8'hfc, 32'h7f00ff80, 32'h00000000, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 8'hfc, 32'h0,        32'hffffff80, 1'b0};
    tbl[14] = '{1'b0, 3'd1, 8'hfe, 32'h0,        32'h00007f00, 1'b0};
    tbl[15] = '{1'b0, 3'd4, 8'hfd, 32'h0,        32'h000000ff, 1'b0};
    tbl[16] = '{1'b1, 3'd4, 8'hfc, 32'h0,        32'h00000000, 1'b1};
    tbl[17] = '{1'b0, 3'd2, 8'hfc, 32'h0,        32'h7f00ff80, 1'b0};
    tbl[18] = '{1'b1, 3'd1, 8'hfe, 32'h1234abcd, 32'h00000000, 1'b0};
    tbl[19] = '{1'b0, 3'd2, 8'hfc, 32'h0,        32'habcdff80, 1'b0};

    n_tests = 0; n_fail = 0;
    m_rd = 0; m_wr = 0; m_err = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    rand_rdy = 1'b0; cur_tbl = 1'b0; cur_t_rdata = '0; cur_t_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_stats();
    @(posedge clk); #1;
    rst = 1'b1;

    // Give every word a known value
    for (int w = 0; w < 64; w++) begin
      rnd = $urandom();
      issue(1'b1, 3'd2, 8'(w * 4), rnd);
    end
    drain();
    check_stats();

    // Directed vectors, back to back
    for (int i = 0; i < 20; i++) begin
      cur_tbl     = 1'b1;
      cur_t_rdata = tbl[i].rdata;
      cur_t_err   = tbl[i].err;
      issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
    end
    cur_tbl = 1'b0;
    drain();
    check_stats();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle();
      end else begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0)  f3 = 3'($urandom_range(0, 7));
        else if (we)                    f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
        a  = 8'($urandom_range(0, 255));
        sz = 1 << f3[1:0];
        if ($urandom_range(0, 3) != 0 && sz <= 4) a = 8'(int'(a) - (int'(a) % sz));
        rnd = $urandom();
        issue(we, f3, a, rnd);
      end
    end
    drain();
    check_stats();

    // Hold under backpressure, then reset mid-response
    issue(1'b1, 3'd2, 8'h10, 32'h13579bdf);
    drain();
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'd2, 8'h10, 32'h0);
    held = 32'h13579bdf;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    check("midrst_rsp_valid_next", 32'(bus.rsp_valid), 32'd0);
    check_stats();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    cur_tbl = 1'b1; cur_t_rdata = 32'h13579bdf; cur_t_err = 1'b0;
    issue(1'b0, 3'd2, 8'h10, 32'h0);
    cur_tbl = 1'b0;
    drain();
    check_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
